// File: rtl/bus_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_wait_ctrl
// Purpose  : CPU bus region decoder with per-region wait states and DTACn.
// Revision : 1.0
// ============================================================================
module bus_wait_ctrl #(
    parameter int                          ADDR_W       = 16,
    parameter int                          NUM_CS       = 8,
    parameter int                          WAIT_W       = 4,
    parameter logic [NUM_CS*ADDR_W-1:0]    REGION_BASE  = '0,
    parameter logic [NUM_CS*ADDR_W-1:0]    REGION_MASK  = '0,
    parameter logic [NUM_CS*WAIT_W-1:0]    REGION_WAIT  = '0,
    parameter logic [NUM_CS-1:0]           REGION_PHASE = '0,
    parameter logic [NUM_CS-1:0]           REGION_RMRD  = '0,
    parameter logic [WAIT_W-1:0]           DEFAULT_WAIT = '0
) (
    input  logic              CLK12,
    input  logic              RESET,
    input  logic              AS,
    input  logic              RWb,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic              RMRD,
    input  logic              CE,
    input  logic              CQ,
    output logic [NUM_CS-1:0] CSn,
    output logic              DTACn,
    output logic              UNMAPPED,
    output logic              RW_L,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CS-1:0]   csn_q, csn_d;
    logic                dtacn_q, dtacn_d;
    logic                unmapped_q, unmapped_d;
    logic                rwl_q, rwl_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                unm_flag_q, unm_flag_d;
    logic                phase_q, phase_d;
    logic                armed_q;

    logic [NUM_CS-1:0]   sel_csn;
    logic [WAIT_W-1:0]   sel_wait;
    logic                sel_phase;
    logic                sel_hit;
    logic                qual;

    // Lowest matching index wins; later matches are ignored once a hit is found.
    always_comb begin
        sel_csn   = '1;
        sel_wait  = DEFAULT_WAIT;
        sel_phase = 1'b0;
        sel_hit   = 1'b0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (!sel_hit &&
                ((ADDR & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                 (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W])) &&
                (!REGION_RMRD[i] || RMRD)) begin
                sel_hit    = 1'b1;
                sel_csn[i] = 1'b0;
                sel_wait   = REGION_WAIT[i*WAIT_W +: WAIT_W];
                sel_phase  = REGION_PHASE[i];
            end
        end
    end

    assign qual = !phase_q || (CE && CQ);

    always_comb begin
        state_d    = state_q;
        csn_d      = csn_q;
        dtacn_d    = dtacn_q;
        unmapped_d = 1'b0;
        rwl_d      = rwl_q;
        cnt_d      = cnt_q;
        unm_flag_d = unm_flag_q;
        phase_d    = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (!AS && armed_q) begin
                    state_d    = ST_WAIT;
                    csn_d      = sel_csn;
                    rwl_d      = RWb;
                    cnt_d      = sel_wait;
                    unm_flag_d = !sel_hit;
                    phase_d    = sel_phase;
                end
            end
            ST_WAIT: begin
                if (AS) begin
                    state_d = ST_IDLE;
                    csn_d   = '1;
                end else if (qual) begin
                    if (cnt_q == '0) begin
                        state_d    = ST_ACK;
                        dtacn_d    = 1'b0;
                        unmapped_d = unm_flag_q;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (AS) begin
                    state_d = ST_IDLE;
                    csn_d   = '1;
                    dtacn_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                csn_d   = '1;
                dtacn_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK12) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            csn_q      <= '1;
            dtacn_q    <= 1'b1;
            unmapped_q <= 1'b0;
            rwl_q      <= 1'b1;
            cnt_q      <= '0;
            unm_flag_q <= 1'b0;
            phase_q    <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            csn_q      <= csn_d;
            dtacn_q    <= dtacn_d;
            unmapped_q <= unmapped_d;
            rwl_q      <= rwl_d;
            cnt_q      <= cnt_d;
            unm_flag_q <= unm_flag_d;
            phase_q    <= phase_d;
            // A strobe held low through reset must be seen high before it counts.
            armed_q    <= armed_q || AS;
        end
    end

    assign CSn      = csn_q;
    assign DTACn    = dtacn_q;
    assign UNMAPPED = unmapped_q;
    assign RW_L     = rwl_q;
    assign BUSY     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_wait_ctrl
// Purpose  : Self-checking bench for bus_wait_ctrl against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_bus_wait_ctrl;

    localparam int NW  = 40;
    localparam int ACC = 2;

    logic        clk = 1'b0;
    logic        RESET, AS, RWb, RMRD, CE, CQ;
    logic [15:0] ADDR;
    logic [2:0]  CSn;
    logic        DTACn, UNMAPPED, RW_L, BUSY;

    int checks = 0;
    int errors = 0;
    logic prev_rwl = 1'b1;

    logic       as_v [NW];
    logic       ce_v [NW];
    logic       cq_v [NW];
    logic [2:0] o_cs [NW];
    logic       o_dt [NW];
    logic       o_um [NW];
    logic       o_rw [NW];
    logic       o_bz [NW];

    always #5 clk = ~clk;

    bus_wait_ctrl #(
        .ADDR_W       (16),
        .NUM_CS       (3),
        .WAIT_W       (4),
        .REGION_BASE  ({16'h0000, 16'h4000, 16'h7C00}),
        .REGION_MASK  ({16'h8000, 16'hC000, 16'hFC00}),
        .REGION_WAIT  ({4'd1, 4'd2, 4'd0}),
        .REGION_PHASE (3'b100),
        .REGION_RMRD  (3'b010),
        .DEFAULT_WAIT (4'd3)
    ) u_dut (
        .CLK12    (clk),
        .RESET    (RESET),
        .AS       (AS),
        .RWb      (RWb),
        .ADDR     (ADDR),
        .RMRD     (RMRD),
        .CE       (CE),
        .CQ       (CQ),
        .CSn      (CSn),
        .DTACn    (DTACn),
        .UNMAPPED (UNMAPPED),
        .RW_L     (RW_L),
        .BUSY     (BUSY)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Region 3 stands for "unmapped".
    function automatic int region_of(input logic [15:0] a, input logic rm);
        if (a[15:10] == 6'b011111)      return 0;
        if (a[15:14] == 2'b01 && rm)    return 1;
        if (!a[15])                     return 2;
        return 3;
    endfunction

    function automatic int wait_of(input int r);
        case (r)
            0:       return 0;
            1:       return 2;
            2:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic logic [2:0] csn_of(input int r);
        logic [2:0] v;
        v = 3'b111;
        if (r < 3) v[r] = 1'b0;
        return v;
    endfunction

    task automatic step_and_check(input string tag, input logic [2:0] cs, input logic dt,
                                  input logic um, input logic rw, input logic bz);
        @(posedge clk);
        #1;
        check_eq({tag, " CSn"}, {29'd0, CSn}, {29'd0, cs});
        check_eq({tag, " DTACn"}, {31'd0, DTACn}, {31'd0, dt});
        check_eq({tag, " UNMAPPED"}, {31'd0, UNMAPPED}, {31'd0, um});
        check_eq({tag, " RW_L"}, {31'd0, RW_L}, {31'd0, rw});
        check_eq({tag, " BUSY"}, {31'd0, BUSY}, {31'd0, bz});
    endtask

    // One access: strobe low from edge ACC to edge rel-1, high elsewhere.
    // mode 0: random CE/CQ; mode 1: CE&CQ true on every 4th edge.
    task automatic run_window(input string name, input logic [15:0] addr, input logic rw,
                              input logic rm, input int rel_off, input int mode);
        int rel, r, need, ack;
        logic ph, done;
        logic [2:0] e_cs;
        logic e_dt, e_um, e_rw, e_bz;
        rel = ACC + rel_off;
        for (int k = 0; k < NW; k++) begin
            as_v[k] = !(k >= ACC && k < rel);
            if (mode == 1) begin
                ce_v[k] = 1'b1;
                cq_v[k] = (k % 4 == 3);
            end else begin
                ce_v[k] = 1'($urandom_range(0, 1));
                cq_v[k] = 1'($urandom_range(0, 1));
            end
        end
        for (int k = 0; k < NW; k++) begin
            AS = as_v[k];
            CE = ce_v[k];
            CQ = cq_v[k];
            if (k == ACC) begin
                ADDR = addr;
                RWb  = rw;
                RMRD = rm;
            end else begin
                ADDR = 16'($urandom);
                RWb  = 1'($urandom_range(0, 1));
                RMRD = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            o_cs[k] = CSn;
            o_dt[k] = DTACn;
            o_um[k] = UNMAPPED;
            o_rw[k] = RW_L;
            o_bz[k] = BUSY;
        end

        r    = region_of(addr, rm);
        ph   = (r == 2);
        need = wait_of(r) + 1;
        ack  = -1;
        done = 1'b0;
        for (int k = ACC + 1; k < rel; k++) begin
            if (!done && (!ph || (ce_v[k] && cq_v[k]))) begin
                need--;
                if (need == 0) begin
                    ack  = k;
                    done = 1'b1;
                end
            end
        end

        for (int k = 0; k < NW; k++) begin
            e_bz = (k >= ACC && k < rel);
            e_cs = e_bz ? csn_of(r) : 3'b111;
            e_dt = !(ack >= 0 && k >= ack && k < rel);
            e_um = (ack >= 0 && k == ack && r == 3);
            e_rw = (k >= ACC) ? rw : prev_rwl;
            check_eq($sformatf("%s k%0d CSn", name, k), {29'd0, o_cs[k]}, {29'd0, e_cs});
            check_eq($sformatf("%s k%0d DTACn", name, k), {31'd0, o_dt[k]}, {31'd0, e_dt});
            check_eq($sformatf("%s k%0d UNMAPPED", name, k), {31'd0, o_um[k]}, {31'd0, e_um});
            check_eq($sformatf("%s k%0d RW_L", name, k), {31'd0, o_rw[k]}, {31'd0, e_rw});
            check_eq($sformatf("%s k%0d BUSY", name, k), {31'd0, o_bz[k]}, {31'd0, e_bz});
        end
        prev_rwl = rw;
    endtask

    initial begin
        logic [15:0] a;
        RESET = 1'b1; AS = 1'b0; RWb = 1'b1; RMRD = 1'b0; CE = 1'b0; CQ = 1'b0; ADDR = 16'h7C10;

        // Reset with strobe low, then strobe still low after reset: no access.
        step_and_check("reset0", 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        step_and_check("reset1", 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) step_and_check($sformatf("unarmed%0d", i), 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        AS = 1'b1;
        step_and_check("arm", 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);

        run_window("rd_r0",     16'h7C10, 1'b1, 1'b0, 4, 0);
        run_window("wr_r0",     16'h7C10, 1'b0, 1'b1, 4, 0);
        run_window("rd_r1",     16'h4800, 1'b1, 1'b1, 8, 0);
        run_window("rd_r1_nrm", 16'h4800, 1'b1, 1'b0, 6, 0);
        run_window("rd_r2_ph",  16'h1234, 1'b1, 1'b0, 14, 1);
        run_window("rd_unmap",  16'h8000, 1'b1, 1'b0, 8, 0);
        run_window("abort_r1",  16'h4800, 1'b1, 1'b1, 2, 0);
        run_window("abort_unm", 16'hFFFF, 1'b0, 1'b0, 4, 0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       a = 16'h7C00 | 16'($urandom_range(0, 16'h03FF));
                1:       a = 16'h4000 | 16'($urandom_range(0, 16'h3FFF));
                default: a = 16'($urandom);
            endcase
            run_window($sformatf("rnd%0d", t), a, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(1, 14), $urandom_range(0, 1));
        end

        // Reset in the middle of a wait while the strobe stays low.
        AS = 1'b0; ADDR = 16'h4800; RMRD = 1'b1; RWb = 1'b0;
        step_and_check("mid_acc", 3'b101, 1'b1, 1'b0, 1'b0, 1'b1);
        step_and_check("mid_wait", 3'b101, 1'b1, 1'b0, 1'b0, 1'b1);
        RESET = 1'b1;
        step_and_check("mid_reset", 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        RESET = 1'b0;
        for (int i = 0; i < 5; i++) step_and_check($sformatf("post_rst%0d", i), 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        AS = 1'b1;
        step_and_check("post_rst_arm", 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);
        AS = 1'b0; ADDR = 16'h7C10; RWb = 1'b1; RMRD = 1'b0;
        step_and_check("post_rst_acc", 3'b110, 1'b1, 1'b0, 1'b1, 1'b1);
        step_and_check("post_rst_ack", 3'b110, 1'b0, 1'b0, 1'b1, 1'b1);
        AS = 1'b1;
        step_and_check("post_rst_rel", 3'b111, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
